// File: rtl/leaf_pkt_pkg.sv
// rtl/leaf_pkt_pkg.sv - BFT leaf packet layout, FSM states and packet builder
package leaf_pkt_pkg;
  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int LEAF_W    = 5;
  localparam int PORT_LSB  = 39;
  localparam int PORT_W    = 4;
  localparam int SEQ_LSB   = 32;
  localparam int SEQ_W     = 7;
  localparam int PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [PKT_W-1:0] pack_pkt(
    input logic [LEAF_W-1:0]    leaf,
    input logic [PORT_W-1:0]    port,
    input logic [SEQ_W-1:0]     seq,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[VALID_BIT]                = 1'b1;
    p[LEAF_LSB +: LEAF_W]       = leaf;
    p[PORT_LSB +: PORT_W]       = port;
    p[SEQ_LSB +: SEQ_W]         = seq;
    p[0 +: PAYLOAD_W]           = payload;
    return p;
  endfunction
endpackage

// File: rtl/leaf_packer_fifo.sv
// rtl/leaf_packer_fifo.sv - single-clock payload FIFO with registered occupancy count
module leaf_packer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == LP_FULL);
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/leaf_stream_packer.sv
// rtl/leaf_stream_packer.sv - credit-paced packer of a 32-bit stream into 49-bit BFT leaf packets
// LEAF_PACKER_SEQ_EN: when defined, packets carry a 7-bit sequence number; otherwise that field is 0.
module leaf_stream_packer
  import leaf_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CREDITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [PAYLOAD_W-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LEAF_W-1:0]    cfg_dest_leaf,
  input  logic [PORT_W-1:0]    cfg_dest_port,
  input  logic                 credit_ret,
  output logic [PKT_W-1:0]     dout_leaf_interface2bft,
  output logic                 resend,
  output logic                 busy,
  output logic                 credit_err
);
  localparam logic [7:0] LP_CREDITS = 8'(CREDITS);

  state_t                r_state;
  logic [LEAF_W-1:0]     r_leaf;
  logic [PORT_W-1:0]     r_port;
  logic [7:0]            r_credits;
  logic                  r_credit_err;
  logic [PKT_W-1:0]      r_dout;
  logic                  r_resend;
  logic                  w_start;
  logic                  w_push;
  logic                  w_emit;
  logic                  w_full;
  logic                  w_empty;
  logic [PAYLOAD_W-1:0]  w_rdata;
  logic [SEQ_W-1:0]      w_seq;

  assign w_start = (r_state == ST_IDLE) & ap_start;
  assign s_ready = (r_state == ST_RUN) & ~w_full;
  assign w_push  = s_valid & s_ready;
  assign w_emit  = (r_state != ST_IDLE) & ~w_empty & (r_credits != 8'd0);

  leaf_packer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAYLOAD_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (s_data),
    .i_pop   (w_emit),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_leaf  <= '0;
      r_port  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (ap_start) begin
          r_state <= ST_RUN;
          r_leaf  <= cfg_dest_leaf;
          r_port  <= cfg_dest_port;
        end
        ST_RUN:   if (!ap_start) r_state <= ST_DRAIN;
        // Restart from drain keeps the destination latched at the original start
        ST_DRAIN: if (ap_start) r_state <= ST_RUN;
                  else if (w_empty) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits    <= LP_CREDITS;
      r_credit_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (ap_start) r_credits <= LP_CREDITS;
    end else begin
      case ({credit_ret, w_emit})
        2'b10: if (r_credits == LP_CREDITS) r_credit_err <= 1'b1;
               else r_credits <= r_credits + 8'd1;
        2'b01:   r_credits <= r_credits - 8'd1;
        default: r_credits <= r_credits;
      endcase
    end
  end

`ifdef LEAF_PACKER_SEQ_EN
  logic [SEQ_W-1:0] r_seq;
  always_ff @(posedge clk) begin
    if (reset || w_start) r_seq <= '0;
    else if (w_emit)      r_seq <= r_seq + 1'b1;
  end
  assign w_seq = r_seq;
`else
  assign w_seq = '0;
`endif

  // Idle cycles only clear the valid bit so the last packet stays visible downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout   <= '0;
      r_resend <= 1'b0;
    end else begin
      r_resend <= w_emit;
      if (w_emit) r_dout <= pack_pkt(r_leaf, r_port, w_seq, w_rdata);
      else        r_dout[VALID_BIT] <= 1'b0;
    end
  end

  assign dout_leaf_interface2bft = r_dout;
  assign resend                  = r_resend;
  assign busy                    = (r_state != ST_IDLE);
  assign credit_err              = r_credit_err;
endmodule
